// File: rtl/uart_pkg.sv
// uart_pkg: shared state encoding, default oversampling ratio and parity helper for the UART cores
package uart_pkg;
  localparam int OVERSAMPLE_DEF = 16;
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} uart_state_e;
  function automatic logic parity_bit(input logic [7:0] data, input logic odd);
    return (^data) ^ odd;
  endfunction
endpackage

// File: rtl/uart_rx_core.sv
// uart_rx_core: synchronises the RX line, samples frames at mid-bit and flags framing/parity errors
module uart_rx_core
  import uart_pkg::*;
#(
  parameter int OVERSAMPLE = OVERSAMPLE_DEF
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       uart_cken_i,
  input  logic       parity_type_i,
  input  logic       parity_en_i,
  input  logic       rx_pin_i,
  output logic [7:0] rx_byte_o,
  output logic       rx_en_o,
  output logic       frame_err_o,
  output logic       parity_err_o
);
  localparam int CW = $clog2(OVERSAMPLE);
  uart_state_e   state_q;
  logic [CW-1:0] cnt_q;
  logic [2:0]    bit_q;
  logic [7:0]    sh_q, byte_q;
  logic          s1_q, s2_q, brk_q, pen_q, ptype_q, pbit_q, en_q, ferr_q, perr_q;
  logic          full;
  assign full         = cnt_q == CW'(OVERSAMPLE - 1);
  assign rx_byte_o    = byte_q;
  assign rx_en_o      = en_q;
  assign frame_err_o  = ferr_q;
  assign parity_err_o = perr_q;
  // brk_q keeps IDLE disarmed after a low stop bit until the line is seen high again
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      sh_q    <= '0;
      byte_q  <= '0;
      s1_q    <= 1'b1;
      s2_q    <= 1'b1;
      brk_q   <= 1'b0;
      pen_q   <= 1'b0;
      ptype_q <= 1'b0;
      pbit_q  <= 1'b0;
      en_q    <= 1'b0;
      ferr_q  <= 1'b0;
      perr_q  <= 1'b0;
    end else begin
      s1_q   <= rx_pin_i;
      s2_q   <= s1_q;
      en_q   <= 1'b0;
      ferr_q <= 1'b0;
      perr_q <= 1'b0;
      if (uart_cken_i) begin
        cnt_q <= cnt_q + CW'(1);
        case (state_q)
          IDLE: begin
            cnt_q   <= '0;
            brk_q   <= brk_q & ~s2_q;
            state_q <= (!s2_q && !brk_q) ? START : IDLE;
          end
          START: if (cnt_q == CW'(OVERSAMPLE / 2 - 1)) begin
            cnt_q   <= '0;
            bit_q   <= '0;
            pen_q   <= parity_en_i;
            ptype_q <= parity_type_i;
            state_q <= s2_q ? IDLE : DATA;
          end
          DATA: if (full) begin
            cnt_q   <= '0;
            sh_q    <= {s2_q, sh_q[7:1]};
            bit_q   <= bit_q + 3'd1;
            state_q <= (bit_q != 3'd7) ? DATA : (pen_q ? PARITY : STOP);
          end
          PARITY: if (full) begin
            cnt_q   <= '0;
            pbit_q  <= s2_q;
            state_q <= STOP;
          end
          STOP: if (full) begin
            cnt_q   <= '0;
            byte_q  <= sh_q;
            en_q    <= 1'b1;
            ferr_q  <= ~s2_q;
            perr_q  <= pen_q && (pbit_q != parity_bit(sh_q, ptype_q));
            brk_q   <= ~s2_q;
            state_q <= IDLE;
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end
endmodule

// File: rtl/uart_tx_core.sv
// uart_tx_core: serialises one byte per frame (start, 8 data LSB first, optional parity, stop)
module uart_tx_core
  import uart_pkg::*;
#(
  parameter int OVERSAMPLE = OVERSAMPLE_DEF
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       uart_cken_i,
  input  logic       parity_type_i,
  input  logic       parity_en_i,
  input  logic [7:0] tx_byte_i,
  input  logic       tx_en_i,
  output logic       tx_ready_o,
  output logic       tx_pin_o,
  output logic       txde_o
);
  localparam int CW = $clog2(OVERSAMPLE);
  uart_state_e   state_q;
  logic [CW-1:0] cnt_q;
  logic [2:0]    bit_q;
  logic [7:0]    sh_q;
  logic          pend_q, pen_q, par_q, pin_q, de_q, ready_q;
  assign tx_ready_o = ready_q;
  assign tx_pin_o   = pin_q;
  assign txde_o     = de_q;
  // pend_q holds the accepted byte until the next cken pulse so the start bit is cken-aligned
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      sh_q    <= '0;
      pend_q  <= 1'b0;
      pen_q   <= 1'b0;
      par_q   <= 1'b0;
      pin_q   <= 1'b1;
      de_q    <= 1'b0;
      ready_q <= 1'b1;
    end else if (state_q == IDLE) begin
      if (tx_en_i) begin
        sh_q    <= tx_byte_i;
        pen_q   <= parity_en_i;
        par_q   <= parity_bit(tx_byte_i, parity_type_i);
        pend_q  <= 1'b1;
        ready_q <= 1'b0;
        state_q <= START;
      end
    end else if (uart_cken_i) begin
      cnt_q <= cnt_q + CW'(1);
      if (pend_q) begin
        pend_q <= 1'b0;
        pin_q  <= 1'b0;
        de_q   <= 1'b1;
        cnt_q  <= '0;
      end else if (cnt_q == CW'(OVERSAMPLE - 1)) begin
        cnt_q <= '0;
        case (state_q)
          START: begin
            state_q <= DATA;
            pin_q   <= sh_q[0];
            sh_q    <= sh_q >> 1;
            bit_q   <= '0;
          end
          DATA: begin
            bit_q   <= bit_q + 3'd1;
            sh_q    <= sh_q >> 1;
            pin_q   <= (bit_q == 3'd7) ? (pen_q ? par_q : 1'b1) : sh_q[0];
            state_q <= (bit_q != 3'd7) ? DATA : (pen_q ? PARITY : STOP);
          end
          PARITY: begin
            state_q <= STOP;
            pin_q   <= 1'b1;
          end
          default: begin
            state_q <= IDLE;
            pin_q   <= 1'b1;
            de_q    <= 1'b0;
            ready_q <= 1'b1;
          end
        endcase
      end
    end
  end
endmodule

// File: rtl/uart_transceiver.sv
// uart_transceiver: full-duplex 8-bit UART with optional parity and RS-485 driver enable
module uart_transceiver
  import uart_pkg::*;
#(
  parameter int OVERSAMPLE = OVERSAMPLE_DEF
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       uart_cken_i,
  input  logic       parity_type_i,
  input  logic       parity_en_i,
  input  logic [7:0] tx_byte_i,
  input  logic       tx_en_i,
  output logic       tx_ready_o,
  output logic       tx_pin_o,
  output logic       txde_o,
  input  logic       rx_pin_i,
  output logic [7:0] rx_byte_o,
  output logic       rx_en_o,
  output logic       frame_err_o,
  output logic       parity_err_o
);
  uart_tx_core #(.OVERSAMPLE(OVERSAMPLE)) u_tx (
    .clk(clk), .resetn(resetn), .uart_cken_i(uart_cken_i),
    .parity_type_i(parity_type_i), .parity_en_i(parity_en_i),
    .tx_byte_i(tx_byte_i), .tx_en_i(tx_en_i),
    .tx_ready_o(tx_ready_o), .tx_pin_o(tx_pin_o), .txde_o(txde_o)
  );
  uart_rx_core #(.OVERSAMPLE(OVERSAMPLE)) u_rx (
    .clk(clk), .resetn(resetn), .uart_cken_i(uart_cken_i),
    .parity_type_i(parity_type_i), .parity_en_i(parity_en_i),
    .rx_pin_i(rx_pin_i), .rx_byte_o(rx_byte_o), .rx_en_o(rx_en_o),
    .frame_err_o(frame_err_o), .parity_err_o(parity_err_o)
  );
endmodule

// File: tb/tb_uart_transceiver.sv
// tb_uart_transceiver: directed loopback and injected-frame checks with hand-computed line patterns
module tb_uart_transceiver;
  logic       clk = 0, resetn = 0, uart_cken_i = 0, parity_type_i = 0, parity_en_i = 0;
  logic [7:0] tx_byte_i = 0;
  logic       tx_en_i = 0, loop = 0, rx_drv = 1;
  logic       tx_ready_o, tx_pin_o, txde_o, rx_pin_i, rx_en_o, frame_err_o, parity_err_o;
  logic [7:0] rx_byte_o;
  int         checks = 0, failures = 0;
  int         rx_cnt = 0, ferr_cnt = 0, perr_cnt = 0;
  logic [7:0] last_byte = 0;
  logic       last_ferr = 0, last_perr = 0;

  assign rx_pin_i = loop ? tx_pin_o : rx_drv;

  uart_transceiver #(.OVERSAMPLE(16)) dut (
    .clk(clk), .resetn(resetn), .uart_cken_i(uart_cken_i),
    .parity_type_i(parity_type_i), .parity_en_i(parity_en_i),
    .tx_byte_i(tx_byte_i), .tx_en_i(tx_en_i), .tx_ready_o(tx_ready_o),
    .tx_pin_o(tx_pin_o), .txde_o(txde_o), .rx_pin_i(rx_pin_i),
    .rx_byte_o(rx_byte_o), .rx_en_o(rx_en_o),
    .frame_err_o(frame_err_o), .parity_err_o(parity_err_o)
  );

  always #5 clk = ~clk;

  initial forever begin
    repeat (3) @(negedge clk);
    uart_cken_i = 1;
    @(negedge clk);
    uart_cken_i = 0;
  end

  always @(negedge clk) begin
    if (rx_en_o) begin
      rx_cnt    <= rx_cnt + 1;
      last_byte <= rx_byte_o;
      last_ferr <= frame_err_o;
      last_perr <= parity_err_o;
    end
    if (frame_err_o) ferr_cnt <= ferr_cnt + 1;
    if (parity_err_o) perr_cnt <= perr_cnt + 1;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog sim_time expired before summary");
    $fatal(1);
  end

  task automatic cken_wait(input int n);
    repeat (n) begin
      @(posedge clk);
      while (uart_cken_i !== 1'b1) @(posedge clk);
    end
    #1;
  endtask

  task automatic strobe_tx(input logic [7:0] b, input logic pen, input logic pt, output logic rdy);
    @(negedge clk);
    tx_byte_i = b; parity_en_i = pen; parity_type_i = pt; tx_en_i = 1;
    @(posedge clk); #1 rdy = tx_ready_o;
    @(negedge clk);
    tx_en_i = 0;
  endtask

  task automatic wait_txde(output logic to);
    to = 1;
    for (int i = 0; i < 400; i++) begin
      if (txde_o === 1'b1) begin to = 0; break; end
      @(posedge clk); #1;
    end
  endtask

  task automatic tx_capture(input logic [7:0] b, input logic pen, input logic pt,
                            output logic [10:0] line, output logic rdy_drop,
                            output logic rdy_end, output logic de_end, output logic to);
    line = '1;
    strobe_tx(b, pen, pt, rdy_drop);
    wait_txde(to);
    if (!to) for (int i = 0; i < (pen ? 11 : 10); i++) begin
      cken_wait(8); line[i] = tx_pin_o; cken_wait(8);
    end
    rdy_end = tx_ready_o; de_end = txde_o;
  endtask

  task automatic rx_send(input logic [7:0] b, input logic pen, input logic pb, input logic stopb);
    loop = 0;
    rx_drv = 0; cken_wait(16);
    for (int i = 0; i < 8; i++) begin rx_drv = b[i]; cken_wait(16); end
    if (pen) begin rx_drv = pb; cken_wait(16); end
    rx_drv = stopb; cken_wait(16);
  endtask

  task automatic test_reset;
    resetn = 0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (tx_pin_o !== 1'b1) begin failures++; $display("FAIL reset_tx_pin got=%b exp=1", tx_pin_o); end
    checks++; if (txde_o !== 1'b0) begin failures++; $display("FAIL reset_txde got=%b exp=0", txde_o); end
    checks++; if (tx_ready_o !== 1'b1) begin failures++; $display("FAIL reset_tx_ready got=%b exp=1", tx_ready_o); end
    checks++; if (rx_byte_o !== 8'h00) begin failures++; $display("FAIL reset_rx_byte got=%h exp=00", rx_byte_o); end
    checks++; if ({rx_en_o, frame_err_o, parity_err_o} !== 3'b000) begin failures++; $display("FAIL reset_strobes got=%b exp=000", {rx_en_o, frame_err_o, parity_err_o}); end
    @(negedge clk); resetn = 1;
    cken_wait(4);
  endtask

  task automatic test_loop_53;
    logic [10:0] line; logic drop, rend, dend, to; int c0, f0, p0;
    loop = 1; c0 = rx_cnt; f0 = ferr_cnt; p0 = perr_cnt;
    tx_capture(8'h53, 0, 0, line, drop, rend, dend, to);
    checks++; if (drop !== 1'b0) begin failures++; $display("FAIL l53_ready_drop got=%b exp=0", drop); end
    checks++; if (to !== 1'b0) begin failures++; $display("FAIL l53_txde_timeout got=%b exp=0", to); end
    checks++; if (line[9:0] !== 10'b1_0101_0011_0) begin failures++; $display("FAIL l53_line got=%b exp=%b", line[9:0], 10'b1010100110); end
    checks++; if ({rend, dend} !== 2'b10) begin failures++; $display("FAIL l53_end_ready_de got=%b exp=10", {rend, dend}); end
    checks++; if (rx_cnt - c0 !== 1) begin failures++; $display("FAIL l53_rx_count got=%0d exp=1", rx_cnt - c0); end
    checks++; if (last_byte !== 8'h53) begin failures++; $display("FAIL l53_rx_byte got=%h exp=53", last_byte); end
    checks++; if ((ferr_cnt - f0) + (perr_cnt - p0) !== 0) begin failures++; $display("FAIL l53_err_strobes got=%0d exp=0", (ferr_cnt - f0) + (perr_cnt - p0)); end
  endtask

  task automatic test_parity_even;
    logic [10:0] line; logic drop, rend, dend, to; int c0, p0;
    loop = 1; c0 = rx_cnt; p0 = perr_cnt;
    tx_capture(8'hAA, 1, 0, line, drop, rend, dend, to);
    checks++; if (line !== 11'b1_0_1010_1010_0) begin failures++; $display("FAIL pe_line got=%b exp=%b", line, 11'b10101010100); end
    checks++; if ({rend, dend} !== 2'b10) begin failures++; $display("FAIL pe_end_ready_de got=%b exp=10", {rend, dend}); end
    checks++; if (rx_cnt - c0 !== 1 || last_byte !== 8'hAA) begin failures++; $display("FAIL pe_rx got=%0d/%h exp=1/aa", rx_cnt - c0, last_byte); end
    checks++; if (perr_cnt - p0 !== 0) begin failures++; $display("FAIL pe_parity_err got=%0d exp=0", perr_cnt - p0); end
  endtask

  task automatic test_parity_odd;
    logic [10:0] line; logic drop, rend, dend, to; int c0, p0;
    loop = 1;
    tx_capture(8'h01, 1, 1, line, drop, rend, dend, to);
    checks++; if (line !== 11'b1_0_0000_0001_0) begin failures++; $display("FAIL po_line got=%b exp=%b", line, 11'b10000000010); end
    cken_wait(4);
    c0 = rx_cnt; p0 = perr_cnt;
    rx_send(8'h01, 1, 1, 1);
    cken_wait(2);
    checks++; if (rx_cnt - c0 !== 1 || last_byte !== 8'h01) begin failures++; $display("FAIL po_inj_rx got=%0d/%h exp=1/01", rx_cnt - c0, last_byte); end
    checks++; if (last_perr !== 1'b1 || perr_cnt - p0 !== 1) begin failures++; $display("FAIL po_inj_parity_err got=%b/%0d exp=1/1", last_perr, perr_cnt - p0); end
    checks++; if (last_ferr !== 1'b0) begin failures++; $display("FAIL po_inj_frame_err got=%b exp=0", last_ferr); end
  endtask

  task automatic test_break;
    int c0;
    parity_en_i = 0; parity_type_i = 0;
    c0 = rx_cnt;
    rx_send(8'h3C, 0, 0, 0);
    cken_wait(1);
    checks++; if (rx_cnt - c0 !== 1 || last_byte !== 8'h3C) begin failures++; $display("FAIL brk_rx got=%0d/%h exp=1/3c", rx_cnt - c0, last_byte); end
    checks++; if (last_ferr !== 1'b1) begin failures++; $display("FAIL brk_frame_err got=%b exp=1", last_ferr); end
    cken_wait(200);
    checks++; if (rx_cnt - c0 !== 1) begin failures++; $display("FAIL brk_hold_quiet got=%0d exp=1", rx_cnt - c0); end
    rx_drv = 1; cken_wait(4);
    rx_send(8'h5A, 0, 0, 1);
    cken_wait(2);
    checks++; if (rx_cnt - c0 !== 2 || last_byte !== 8'h5A || last_ferr !== 1'b0) begin failures++; $display("FAIL brk_recover got=%0d/%h/%b exp=2/5a/0", rx_cnt - c0, last_byte, last_ferr); end
  endtask

  task automatic test_ignore_and_glitch;
    logic drop, to; int c0, e0; bit done;
    loop = 1; c0 = rx_cnt;
    strobe_tx(8'h53, 0, 0, drop);
    wait_txde(to);
    cken_wait(30);
    strobe_tx(8'h11, 0, 0, drop);
    checks++; if (drop !== 1'b0) begin failures++; $display("FAIL ign_busy_ready got=%b exp=0", drop); end
    done = 0;
    for (int i = 0; i < 2000; i++) begin
      if (tx_ready_o === 1'b1) begin done = 1; break; end
      @(posedge clk); #1;
    end
    checks++; if (!done) begin failures++; $display("FAIL ign_ready_timeout got=0 exp=1"); end
    cken_wait(200);
    checks++; if (rx_cnt - c0 !== 1 || last_byte !== 8'h53 || txde_o !== 1'b0) begin failures++; $display("FAIL ign_only_53 got=%0d/%h/%b exp=1/53/0", rx_cnt - c0, last_byte, txde_o); end
    loop = 0; rx_drv = 1; c0 = rx_cnt; e0 = ferr_cnt + perr_cnt;
    cken_wait(1); rx_drv = 0; cken_wait(1); rx_drv = 1;
    cken_wait(40);
    checks++; if (rx_cnt - c0 !== 0 || ferr_cnt + perr_cnt - e0 !== 0) begin failures++; $display("FAIL glitch_no_strobe got=%0d/%0d exp=0/0", rx_cnt - c0, ferr_cnt + perr_cnt - e0); end
  endtask

  task automatic test_reset_mid;
    logic [10:0] line; logic drop, rend, dend, to; int c0;
    loop = 1; c0 = rx_cnt;
    strobe_tx(8'h53, 0, 0, drop);
    wait_txde(to);
    cken_wait(70);
    checks++; if ({tx_pin_o, txde_o} !== 2'b01) begin failures++; $display("FAIL rm_pre_line got=%b exp=01", {tx_pin_o, txde_o}); end
    resetn = 0; #1;
    checks++; if ({tx_pin_o, txde_o, tx_ready_o} !== 3'b101) begin failures++; $display("FAIL rm_tx_outputs got=%b exp=101", {tx_pin_o, txde_o, tx_ready_o}); end
    checks++; if ({rx_byte_o, rx_en_o, frame_err_o, parity_err_o} !== 11'h0) begin failures++; $display("FAIL rm_rx_outputs got=%h exp=0", {rx_byte_o, rx_en_o, frame_err_o, parity_err_o}); end
    repeat (5) @(negedge clk);
    resetn = 1;
    cken_wait(20);
    checks++; if (rx_cnt - c0 !== 0) begin failures++; $display("FAIL rm_aborted_rx got=%0d exp=0", rx_cnt - c0); end
    tx_capture(8'h53, 0, 0, line, drop, rend, dend, to);
    checks++; if (line[9:0] !== 10'b1_0101_0011_0 || rend !== 1'b1) begin failures++; $display("FAIL rm_fresh_line got=%b/%b exp=1010100110/1", line[9:0], rend); end
    checks++; if (rx_cnt - c0 !== 1 || last_byte !== 8'h53) begin failures++; $display("FAIL rm_fresh_rx got=%0d/%h exp=1/53", rx_cnt - c0, last_byte); end
  endtask

  initial begin
    test_reset;
    test_loop_53;
    test_parity_even;
    test_parity_odd;
    test_break;
    test_ignore_and_glitch;
    test_reset_mid;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
